// File: rtl/controlador_int.sv
// controlador_int: prioritised, vectored interrupt controller.
// Rising edges on irq are latched into pending. A software mask, a global
// enable (gie) and the in-service levels (isr) select one candidate, which is
// offered to the CPU through an int_req/int_ack handshake. Line 0 has the
// highest priority. Only sources of strictly higher priority than the lowest
// in-service level may nest. Mask, pending and in-service registers are
// memory-mapped on the data bus.
module controlador_int #(
  parameter int          N_IRQ      = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0004,
  parameter logic [15:0] MASK_ADDR  = 16'hFF10,
  parameter logic [15:0] PEND_ADDR  = 16'hFF11,
  parameter logic [15:0] ISR_ADDR   = 16'hFF12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             we,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             int_req,
  output logic [15:0]      int_vec,
  input  logic             int_ack,
  input  logic             int_ret
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] mask;
  logic             gie;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] isr;
  logic [0:0]       state;
  logic [IW-1:0]    idx;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] isr_low;
  logic [N_IRQ-1:0] allowed;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] w1c_clr;
  logic [N_IRQ-1:0] ack_onehot;
  logic [N_IRQ-1:0] ret_clr;
  logic             cand_valid;
  logic [IW-1:0]    cand_idx;
  logic             mask_wr;
  logic             pend_wr;
  logic             acked;
  logic             withdraw;

  assign rise     = irq & ~irq_q;
  assign mask_wr  = we && (addr == MASK_ADDR);
  assign pend_wr  = we && (addr == PEND_ADDR);
  assign acked    = (state == REQ) && int_ack;
  assign int_req  = (state == REQ);

  // Lowest set bit of isr is the level currently being served; only lines
  // strictly below its index may interrupt it.
  assign isr_low  = isr & (~isr + N_IRQ'(1));
  assign allowed  = (isr == '0) ? '1 : (isr_low - N_IRQ'(1));
  assign eligible = pending & mask & allowed & {N_IRQ{gie}};

  assign w1c_clr  = pend_wr ? wdata[N_IRQ-1:0] : '0;
  assign ret_clr  = int_ret ? isr_low : '0;

  // Software withdrew the request it is currently offering.
  assign withdraw = !(pending[idx] && mask[idx]) || !gie;

  // Fixed-priority pick: lowest eligible index wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        cand_valid = 1'b1;
        cand_idx   = IW'(i);
      end
    end
  end

  // One-hot of the line being acknowledged this cycle.
  always_comb begin
    ack_onehot = '0;
    if (acked) ack_onehot[idx] = 1'b1;
  end

  // Edge detector, mask/gie, pending and in-service registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (!reset) begin
      mask    <= '0;
      gie     <= 1'b0;
      pending <= '0;
      isr     <= '0;
    end else begin
      if (mask_wr) begin
        mask <= wdata[N_IRQ-1:0];
        gie  <= wdata[15];
      end
      // A new edge outranks any clear (W1C or ack) of the same bit.
      pending <= (pending & ~(w1c_clr | ack_onehot)) | rise;
      // Return clears using the old isr; the ack set is applied on top.
      isr     <= (isr & ~ret_clr) | ack_onehot;
    end
  end

  // Request FSM: latch one vector and hold it until ack or withdrawal.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      int_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_valid) begin
            state   <= REQ;
            idx     <= cand_idx;
            int_vec <= VEC_BASE + 16'(cand_idx) * VEC_STRIDE;
          end
        end
        REQ: begin
          if (int_ack || withdraw) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      MASK_ADDR: begin
        rdata[15]          = gie;
        rdata[N_IRQ-1:0]   = mask;
      end
      PEND_ADDR: rdata[N_IRQ-1:0] = pending;
      ISR_ADDR:  rdata[N_IRQ-1:0] = isr;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: doc/controlador_int.md
Name: controlador_int

Overview:
- Prioritised, vectored interrupt controller between the interrupt sources (timer `interrupcion[7:0]` and I/O) and the single-cycle CPU.
- Latches rising edges, applies a software mask and fixed priority, and presents one vector to the CPU with a req/ack handshake.
- Tracks in-service levels so that only strictly higher-priority sources nest.
- Memory-mapped on the data bus for mask, pending and in-service access.

Parameters:
- N_IRQ, 8, number of interrupt lines; index 0 is highest priority.
- VEC_BASE, 16'h0100, vector address of line 0.
- VEC_STRIDE, 16'h0004, address spacing between consecutive vectors.
- MASK_ADDR, 16'hFF10, mask/control register address.
- PEND_ADDR, 16'hFF11, pending register address (read, W1C).
- ISR_ADDR, 16'hFF12, in-service register address (read only).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset: reset=0 at a rising clk edge resets the block.
- irq  input  N_IRQ  interrupt source lines, edge-triggered on rising edge.
- we  input  1  bus write strobe.
- addr  input  16  bus address.
- wdata  input  16  bus write data.
- rdata  output  16  bus read data, combinational.
- int_req  output  1  interrupt request to the CPU.
- int_vec  output  16  vector address; valid while int_req=1.
- int_ack  input  1  CPU accepts the current request (one-cycle pulse).
- int_ret  input  1  CPU executed return-from-interrupt (one-cycle pulse).

Behaviour:
- Reset (reset=0 at a clk edge):
  - mask=0, gie=0, pending=0, isr=0, state=IDLE, int_req=0, int_vec=0.
  - irq_q loads irq, so lines already high at reset release produce no edge.
- Edge detect: irq_q <= irq every cycle. pending[i] is set when irq[i]=1 and irq_q[i]=0. Pending sets regardless of mask.
- Register writes (we=1):
  - MASK_ADDR: mask <= wdata[N_IRQ-1:0], gie <= wdata[15].
  - PEND_ADDR: pending[i] cleared where wdata[i]=1.
  - ISR_ADDR and other addresses: ignored.
- Register reads (rdata):
  - MASK_ADDR: {gie, 0..., mask}.
  - PEND_ADDR: pending, zero-extended.
  - ISR_ADDR: isr, zero-extended.
  - Any other address: 0.
- Candidate: lowest index i with pending[i]&mask[i]=1 and i < lowest set index of isr (any i if isr=0). No candidate when gie=0.
- FSM, 2 states:
  - IDLE: int_req=0. If a candidate exists, go to REQ; latch idx and int_vec = VEC_BASE + idx*VEC_STRIDE (16-bit, wrap-around ignored).
  - REQ: int_req=1. idx and int_vec stay stable; a later higher-priority candidate does not replace them.
    - int_ack=1: pending[idx] cleared, isr[idx] set, go to IDLE.
    - Otherwise, if pending[idx]&mask[idx]=0 or gie=0 (cleared by software): withdraw, go to IDLE, int_req=0 next cycle.
- Latency: an irq edge sampled at clk edge k sets pending at k. int_req=1 after edge k+1. Minimum request-to-request spacing is 1 IDLE cycle.
- int_ret: clears the lowest-index set bit of isr. Ignored when isr=0. int_ack outside REQ is ignored.
- Simultaneous events, same cycle:
  - int_ack and int_ret: the ret clear uses the old isr, then the ack set is applied.
  - New edge on pending[idx] and ack clear of the same bit: bit stays set, so the new event is kept.
  - New edge and W1C on the same bit: edge wins.
  - Mask write and candidate evaluation: the new mask is used from the next cycle.
- Reset mid-REQ: int_req drops after that edge; all state is lost.

Test Plan:
- Reset with irq=8'h01 held, then mask=0x8001 -> no int_req (no edge), pending=0.
- mask=0x8001; irq[0] rises at edge k -> pending=0x01 at k, int_req=1 and int_vec=16'h0100 after k+1. int_ack -> isr=0x01, pending=0, int_req=0.
- isr=0x04 (line 2 in service); lines 1 and 5 rise together -> request for line 1 only (int_vec=0x0104), nesting to isr=0x06. Line 5 is requested only after two int_ret pulses (isr 0x06→0x04→0x00).
- In REQ for line 3, write PEND_ADDR wdata=0x0008 -> int_req=0 next cycle, state IDLE, isr unchanged.
- mask=0x00FF (gie=0); irq[4] edge -> pending=0x10, no int_req. Write mask=0x80FF -> int_req with int_vec=0x0110.
- In REQ, int_ack while irq[idx] has a new rising edge in the same cycle -> isr bit set, pending bit still 1. A second request follows only if priority allows.
